// File: rtl/uart_pkg.sv
// Shared UART definitions: baud constants, requester limits and the TX arbiter FSM encoding.
package uart_pkg;

    localparam int CLK_FREQ      = 100_000_000;
    localparam int BAUD_RATE     = 9600;
    localparam int BIT_PER_CLOCK = 10416;

    localparam int N_REQ_MIN = 2;
    localparam int N_REQ_MAX = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } arb_state_e;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo N_REQ.
module uart_rr_picker
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [IW-1:0]    winner_o,
    output logic             valid_o
);

    logic [IW-1:0] idx;

    // Explicit wrap at N_REQ-1 keeps non-power-of-two counts from visiting unused indices.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = ptr_i;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
            if (!valid_o && req_i[idx]) begin
                valid_o  = 1'b1;
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX core among N_REQ byte producers: round-robin grant, start pulse,
// busy handshake tracking and a watchdog for a core that never raises tx_busy.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int BUSY_WAIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*8-1:0]       req_data,
    output logic [N_REQ-1:0]         ack,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    input  logic                     tx_busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     arb_busy,
    output logic                     err_nostart
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(BUSY_WAIT);

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [IW-1:0]    grant_q, grant_d;
    logic             tx_start_q, tx_start_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             err_q, err_d;

    logic [IW-1:0]    win;
    logic             win_vld;
    logic [7:0]       win_byte;

    uart_rr_picker #(.N_REQ(N_REQ)) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .winner_o (win),
        .valid_o  (win_vld)
    );

    always_comb begin
        win_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == IW'(i)) win_byte = req_data[i*8 +: 8];
        end
    end

    // Start/ack/err are computed one state early so they leave the block registered.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        grant_d    = grant_q;
        tx_start_d = 1'b0;
        ack_d      = '0;
        err_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_vld && !tx_busy) begin
                    tx_data_d  = win_byte;
                    grant_d    = win;
                    ptr_d      = win;
                    tx_start_d = 1'b1;
                    ack_d      = {{(N_REQ-1){1'b0}}, 1'b1} << win;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_LO;
                end else if (cnt_q == CW'(BUSY_WAIT - 2)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= IW'(N_REQ - 1);
            cnt_q      <= '0;
            tx_data_q  <= '0;
            grant_q    <= '0;
            tx_start_q <= 1'b0;
            ack_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            grant_q    <= grant_d;
            tx_start_q <= tx_start_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign ack         = ack_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_q;
    assign arb_busy    = (state_q != ST_IDLE);
    assign err_nostart = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small TX-core model and a grant scoreboard.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int BW    = 4;
    localparam int FRAME = 12;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   ack;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy;
    logic [1:0]     grant_id;
    logic           arb_busy;
    logic           err_nostart;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .BUSY_WAIT(BW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .arb_busy    (arb_busy),
        .err_nostart (err_nostart)
    );

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] bq[N][$];
    int         acks[N];
    int total = 0, bad = 0, cnt = 0;
    int start_cyc = -1, drop_cyc = -1, err_cyc = -1, fall_cyc = -1;
    int n_start = 0, n_err = 0, busy_left = 0;
    bit stub = 0, force_busy = 0, chk_b2b = 0, model_busy = 0, prev_arb = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs 1ns after the edge, then update requesters and the core model.
    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        cnt++;
        if (ack != '0) chk("ack_with_start", tx_start, 1);
        if (tx_start) begin
            n_start++;
            if (chk_b2b && drop_cyc >= 0) chk("b2b_gap", cnt - drop_cyc, 2);
            chk("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("grant_id", grant_id, e.id);
                chk("tx_data", tx_data, e.data);
                chk("ack_onehot", ack, 1 << e.id);
            end
            start_cyc = cnt;
        end
        if (err_nostart) begin
            n_err++;
            err_cyc = cnt;
        end
        if (prev_arb && !arb_busy) fall_cyc = cnt;
        prev_arb = arb_busy;
        for (int i = 0; i < N; i++) begin
            if (ack[i]) begin
                acks[i]++;
                if (bq[i].size() > 0) void'(bq[i].pop_front());
                if (bq[i].size() == 0) req[i] = 1'b0;
                else req_data[i*8 +: 8] = bq[i][0];
            end
        end
        if (tx_start && !stub) begin
            model_busy = 1'b1;
            busy_left  = FRAME;
        end else if (model_busy) begin
            busy_left--;
            if (busy_left == 0) begin
                model_busy = 1'b0;
                drop_cyc   = cnt;
            end
        end
        tx_busy = model_busy | force_busy;
    endtask

    task automatic give(input int i, input logic [7:0] b);
        bq[i].push_back(b);
        if (!req[i]) begin
            req[i] = 1'b1;
            req_data[i*8 +: 8] = b;
        end
    endtask

    task automatic expect_grant(input int i, input logic [7:0] b);
        sb.push_back('{i, b});
    endtask

    task automatic wait_start(input int maxc);
        int n0 = n_start;
        int k  = 0;
        while (n_start == n0 && k < maxc) begin
            cyc();
            k++;
        end
        chk("start_timeout", n_start != n0, 1);
    endtask

    task automatic drain(input int maxc);
        int k = 0;
        while (!(sb.size() == 0 && req == '0 && !arb_busy && !tx_busy) && k < maxc) begin
            cyc();
            k++;
        end
        chk("drain_timeout", k < maxc, 1);
    endtask

    task automatic clear_acks();
        for (int i = 0; i < N; i++) acks[i] = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx_start"}, tx_start, 0);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_grant_id"}, grant_id, 0);
        chk({tag, "_arb_busy"}, arb_busy, 0);
        chk({tag, "_err"}, err_nostart, 0);
    endtask

    initial begin
        int st, c0, n0, ri;
        logic [7:0] rb;
        rst = 1'b0; req = '0; req_data = '0; tx_busy = 1'b0;
        clear_acks();
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("rst");
        @(negedge clk) rst = 1'b1;
        cyc(); cyc();

        // Single request: start one cycle after sampling, arb_busy drops a cycle after tx_busy.
        expect_grant(0, 8'h41);
        give(0, 8'h41);
        cyc();
        chk("single_latency", tx_start, 1);
        drain(100);
        chk("arb_fall", fall_cyc - drop_cyc, 1);

        // Simultaneous requests from a fresh pointer: 0,1,2,3 back to back.
        rst = 1'b0;
        #1 check_reset_outputs("rst2");
        @(negedge clk) rst = 1'b1;
        clear_acks();
        for (int i = 0; i < N; i++) begin
            expect_grant(i, 8'h31 + 8'(i));
            give(i, 8'h31 + 8'(i));
        end
        wait_start(10);
        chk_b2b = 1'b1;
        drain(300);
        chk_b2b = 1'b0;
        for (int i = 0; i < N; i++) chk("simul_ack_cnt", acks[i], 1);

        // Fairness: 0 and 2 keep requesting, grants alternate.
        clear_acks();
        for (int k = 0; k < 3; k++) begin
            give(0, 8'hAA); give(2, 8'h55);
            expect_grant(0, 8'hAA); expect_grant(2, 8'h55);
        end
        drain(400);
        chk("fair_ack0", acks[0], 3);
        chk("fair_ack2", acks[2], 3);
        chk("fair_ack1", acks[1], 0);
        chk("fair_ack3", acks[3], 0);

        // Watchdog: core never goes busy; requester 2 must beat the repeated request from 1.
        stub = 1'b1; n_err = 0;
        expect_grant(1, 8'h7E);
        give(1, 8'h7E); give(1, 8'h7E);
        wait_start(10);
        st = start_cyc;
        give(2, 8'h22);
        expect_grant(2, 8'h22);
        expect_grant(1, 8'h7E);
        for (int k = 0; k < 20 && n_err == 0; k++) cyc();
        chk("err_seen", n_err, 1);
        chk("err_time", err_cyc - st, BW);
        chk("idle_after_err", arb_busy, 0);
        drain(100);
        chk("err_count", n_err, 3);
        stub = 1'b0;

        // Core already busy: no start while held high, grant on the edge it is seen low.
        force_busy = 1'b1;
        tx_busy    = 1'b1;
        give(3, 8'h5A);
        expect_grant(3, 8'h5A);
        n0 = n_start;
        repeat (50) cyc();
        chk("no_start_busy", n_start - n0, 0);
        force_busy = 1'b0;
        tx_busy    = model_busy;
        c0 = cnt;
        wait_start(10);
        chk("grant_after_busy", start_cyc - c0, 1);
        drain(100);

        // Reset during WAIT_LO: outputs clear at once, pointer restarts at requester 0.
        expect_grant(0, 8'h10);
        give(0, 8'h10);
        wait_start(10);
        cyc(); cyc(); cyc();
        chk("in_wait_lo", {arb_busy, tx_busy}, 2'b11);
        #2 rst = 1'b0;
        #1 check_reset_outputs("rst_mid");
        model_busy = 1'b0; busy_left = 0; tx_busy = 1'b0;
        give(0, 8'hC0); give(1, 8'hC1);
        expect_grant(0, 8'hC0); expect_grant(1, 8'hC1);
        @(negedge clk) rst = 1'b1;
        drain(200);

        for (int k = 0; k < 10; k++) begin
            ri = int'($urandom_range(0, N - 1));
            rb = 8'($urandom);
            expect_grant(ri, rb);
            give(ri, rb);
            drain(100);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART TX core among `N_REQ` byte producers. It sits between the requesters and the `uart_top` TX path. It latches the winning requester's byte, issues a one-cycle `tx_start`, then holds off further grants until the core's `tx_busy` rises and falls again. A watchdog flags a core that never acknowledges `tx_start`.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `BUSY_WAIT`, 4: max cycles after `tx_start` for `tx_busy` to rise, ≥2.
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  `N_REQ`  level request per requester; held until its `ack`.
- `req_data`  in  `N_REQ*8`  byte of requester i at `[8i+7:8i]`; stable while `req[i]` is high.
- `ack`  out  `N_REQ`  one-cycle pulse: requester's byte latched and issued.
- `tx_start`  out  1  one-cycle start pulse to the TX core.
- `tx_data`  out  8  byte to the TX core; held from `tx_start` until return to IDLE.
- `tx_busy`  in  1  busy flag from the TX core.
- `grant_id`  out  `$clog2(N_REQ)`  index of the current or last granted requester.
- `arb_busy`  out  1  high in any state except IDLE.
- `err_nostart`  out  1  one-cycle pulse when the watchdog expires.

## Operation
- FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO.
- **IDLE**, when `|req` and `!tx_busy`:
  - Select the winner w by round-robin.
  - Register `tx_data <= req_data[w]`, `grant_id <= w`, `ptr <= w`.
  - Go to ISSUE.
- **IDLE**, when `tx_busy` is high: no grant, even with requests pending.
- **ISSUE**, exactly one cycle:
  - `tx_start = 1` and `ack[w] = 1`, both registered outputs.
  - Clear the wait counter; go to WAIT_HI.
- **WAIT_HI**:
  - `tx_busy` high → go to WAIT_LO.
  - Otherwise increment the counter. When it reaches `BUSY_WAIT-1`, pulse `err_nostart` and go to IDLE.
- **WAIT_LO**: `tx_busy` low → go to IDLE.
- **Round-robin**:
  - Priority order is `ptr+1, ptr+2, …`, wrapping modulo `N_REQ`; correct for non-power-of-two `N_REQ`.
  - `ptr` resets to `N_REQ-1`, so requester 0 wins first after reset.
  - `ptr` advances on every grant, including grants that later time out.
- **Requester rule**:
  - Drop `req[i]` or present the next byte on the edge after `ack[i]`.
  - `req` is not re-sampled until the arbiter returns to IDLE, which is ≥3 cycles later.
- **Reset**, asynchronous and effective immediately: state IDLE, `ptr = N_REQ-1`, counter 0.
- **Reset values**: `tx_start`, `ack`, `tx_data`, `grant_id`, `arb_busy`, `err_nostart` all 0.
- **Reset mid-transfer**: the in-flight byte is abandoned with no further `ack`. The TX core is reset by the same `rst`.

## Timing
- Request to start: `req` sampled high at IDLE edge n → `tx_start` and `ack` high during cycle n+1.
- `tx_start` width: exactly 1 cycle. It is never asserted while `tx_busy` was high at the grant edge.
- Back-to-back transfers: `tx_busy` sampled low at edge m → IDLE at m+1 → next `tx_start` during cycle m+2.
- Serial frame: 1 start bit, 8 data bits LSB-first, 1 stop bit. At 9600 baud each bit is `BIT_PER_CLOCK` = 10416 clocks. Frame cadence is governed by the core, not by this block.
- Watchdog: `err_nostart` pulses `BUSY_WAIT` cycles after the `tx_start` cycle if `tx_busy` never rose.

## Structure
- Shared package `uart_pkg`:
  - FSM state encodings.
  - `CLK_FREQ = 100_000_000`, `BAUD_RATE = 9600`, `BIT_PER_CLOCK = 10416`.
  - Requester-count limits.
- Sub-module `uart_rr_picker`: combinational. Inputs are `req` and `ptr`; outputs are winner index and valid. It is reused by future UART RX/TX muxes.
- Top level is the FSM, the data latch and the watchdog counter. Instantiate with `uart_top` in the integration bench.

## Test plan
- **Single request:** `req[0]` high, byte `0x41` → `ack[0]` and `tx_start` pulse together one cycle after sampling; serial monitor decodes `0x41`; `arb_busy` falls 1 cycle after `tx_busy` falls.
- **Simultaneous requests:** all four requesters assert at once with `0x31`, `0x32`, `0x33`, `0x34` → frames in order `31 32 33 34`; each `ack` pulses once; consecutive `tx_start` pulses are 2 cycles after each `tx_busy` fall.
- **Fairness:** `req[0]` and `req[2]` re-asserted immediately after every ack, bytes `0xAA` and `0x55` → grants alternate 0, 2, 0, 2 over 6 frames; requesters 1 and 3 are never acked.
- **Watchdog:** `tx_busy` stubbed to 0, `req[1]` with `0x7E` → `err_nostart` pulses 4 cycles after `tx_start`; arbiter returns to IDLE; the next pending `req[2]` is granted before `req[1]`.
- **Core already busy:** `tx_busy` forced high for 50 cycles while `req[3]` is pending → no `tx_start`; grant occurs on the edge after `tx_busy` falls.
- **Reset mid-frame:** `rst` low during WAIT_LO → all outputs 0 in the same time step; after release, pending `req[0]` and `req[1]` are granted in order 0 then 1; 10 random bytes then pass with a zero fail count.
